// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32 pipeline.
// Owns the PC, the instruction-memory request handshake, a one-entry skid
// buffer for results that decode cannot take yet, and the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned PC_STEP   = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        if_id_enable,
   input  logic        mux_sel_IF,
   input  logic        IF_flush,
   input  logic [31:0] pc_branch_value,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_flush_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DROP
   } fetchState_e;

   fetchState_e state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] reqAddr_q, reqAddr_d;
   logic [31:0] skidData_q, skidData_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifIdPc_q, ifIdPc_d;
   logic        valid_q, valid_d;

   logic        complete;
   logic [31:0] nextSeqPc;
   logic        haveData;
   logic [31:0] fetchData;
   logic [31:0] fetchPc;

   assign imem_req        = (state_q == REQ) || (state_q == DROP);
   assign imem_addr       = reqAddr_q;
   assign complete        = imem_req && imem_ready;
   assign nextSeqPc       = reqAddr_q + 32'(PC_STEP);
   assign instruction_out = instr_q;
   assign pc_out          = ifIdPc_q;
   assign valid_out       = valid_q;

   // Fetch FSM: next state, PC, request address, skid capture and the word offered to IF/ID
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      reqAddr_d  = reqAddr_q;
      skidData_d = skidData_q;
      haveData   = 1'b0;
      fetchData  = '0;
      fetchPc    = '0;
      unique case (state_q)
         IDLE: begin
            if (mux_sel_IF) begin
               pc_d = pc_branch_value;
            end else if (pc_enable) begin
               reqAddr_d = pc_q;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (complete && IF_flush) begin
               pc_d    = pc_branch_value;
               state_d = IDLE;
            end else if (complete) begin
               pc_d = mux_sel_IF ? pc_branch_value : nextSeqPc;
               if (if_id_enable) begin
                  haveData  = 1'b1;
                  fetchData = imem_rdata;
                  fetchPc   = reqAddr_q;
                  if (pc_enable && !mux_sel_IF) begin
                     reqAddr_d = nextSeqPc;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  skidData_d = imem_rdata;
                  state_d    = HOLD;
               end
            end else if (IF_flush) begin
               pc_d    = pc_branch_value;
               state_d = DROP;
            end else if (mux_sel_IF) begin
               pc_d = pc_branch_value;
            end
         end
         HOLD: begin
            if (IF_flush) begin
               pc_d    = pc_branch_value;
               state_d = IDLE;
            end else begin
               if (mux_sel_IF) begin
                  pc_d = pc_branch_value;
               end
               if (if_id_enable) begin
                  haveData  = 1'b1;
                  fetchData = skidData_q;
                  fetchPc   = reqAddr_q;
                  if (pc_enable && !mux_sel_IF) begin
                     reqAddr_d = pc_q;
                     state_d   = REQ;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (mux_sel_IF) begin
               pc_d = pc_branch_value;
            end
            if (complete) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // IF/ID next value: flush beats load, load beats bubble, otherwise hold
   always_comb begin
      instr_d  = instr_q;
      ifIdPc_d = ifIdPc_q;
      valid_d  = valid_q;
      if (IF_flush) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (if_id_enable) begin
         if (haveData) begin
            instr_d  = fetchData;
            ifIdPc_d = fetchPc;
            valid_d  = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   // State, PC, skid and IF/ID registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         reqAddr_q  <= RESET_PC;
         skidData_q <= '0;
         instr_q    <= NOP_INSTR;
         ifIdPc_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         reqAddr_q  <= reqAddr_d;
         skidData_q <= skidData_d;
         instr_q    <= instr_d;
         ifIdPc_q   <= ifIdPc_d;
         valid_q    <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetch_q;
   logic [31:0] perfFlush_q;
   logic        fetchKept;

   assign fetchKept        = (state_q == REQ) && complete && !IF_flush;
   assign perf_fetch_count = perfFetch_q;
   assign perf_flush_count = perfFlush_q;

   // Saturating counters of kept fetch completions and of flush cycles
   always_ff @(posedge clock) begin
      if (!reset) begin
         perfFetch_q <= '0;
         perfFlush_q <= '0;
      end else begin
         if (fetchKept && (perfFetch_q != 32'hFFFF_FFFF)) begin
            perfFetch_q <= perfFetch_q + 32'd1;
         end
         if (IF_flush && (perfFlush_q != 32'hFFFF_FFFF)) begin
            perfFlush_q <= perfFlush_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed walk through the fetch scenarios followed by
// randomized hazard/flush/memory-latency traffic, all compared each cycle
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_enable;
   logic        if_id_enable;
   logic        mux_sel_IF;
   logic        IF_flush;
   logic [31:0] pc_branch_value;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_flush_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fetch_stage dut (
      .clock          (clock),
      .reset          (reset),
      .pc_enable      (pc_enable),
      .if_id_enable   (if_id_enable),
      .mux_sel_IF     (mux_sel_IF),
      .IF_flush       (IF_flush),
      .pc_branch_value(pc_branch_value),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .instruction_out(instruction_out),
      .pc_out         (pc_out),
      .valid_out      (valid_out)
`ifdef FETCH_PERF_CNT_EN
     ,.perf_fetch_count(perf_fetch_count),
      .perf_flush_count(perf_flush_count)
`endif
   );

   // Model: a pending request (busy, possibly already squashed), a skid queue
   // of at most one fetched word, the PC, and the expected IF/ID contents.
   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetched_t;

   fetched_t    skidQ[$];
   logic [31:0] mPc, mAddr, eInstr, ePc;
   bit          mBusy, mDead, eValid;
   logic [31:0] mFetchCnt, mFlushCnt;

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compare every DUT output with the model
   task automatic compareModel();
      checkOutput("imem_req", 32'(imem_req), 32'(mBusy));
      checkOutput("imem_addr", imem_addr, mAddr);
      checkOutput("instruction_out", instruction_out, eInstr);
      checkOutput("pc_out", pc_out, ePc);
      checkOutput("valid_out", 32'(valid_out), 32'(eValid));
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_fetch_count", perf_fetch_count, mFetchCnt);
      checkOutput("perf_flush_count", perf_flush_count, mFlushCnt);
`endif
   endtask

   // Advance the model by one clock edge using the inputs now being driven
   task automatic stepModel();
      bit          done, live, wasIdle, wasHold, gAvail, issue;
      logic [31:0] nPc, gWord, gPc;
      if (!reset) begin
         mPc = 32'h0; mAddr = 32'h0; mBusy = 0; mDead = 0;
         skidQ.delete();
         eInstr = NOP; ePc = 32'h0; eValid = 0;
         mFetchCnt = 32'h0; mFlushCnt = 32'h0;
         return;
      end
      done    = mBusy && imem_ready;
      wasHold = (skidQ.size() != 0);
      wasIdle = !mBusy && !wasHold;
      live    = (mBusy && !mDead) || wasHold;
      gAvail  = 0; gWord = 32'h0; gPc = 32'h0;
      if (wasHold) begin
         gAvail = 1; gWord = skidQ[0].word; gPc = skidQ[0].pc;
      end else if (done && !mDead) begin
         gAvail = 1; gWord = imem_rdata; gPc = mAddr;
      end
      if (IF_flush) begin
         eInstr = NOP; eValid = 0;
      end else if (if_id_enable) begin
         if (gAvail) begin
            eInstr = gWord; ePc = gPc; eValid = 1;
         end else begin
            eInstr = NOP; eValid = 0;
         end
      end
      if (IF_flush && mFlushCnt != 32'hFFFF_FFFF) mFlushCnt++;
      if (done && !mDead && !IF_flush && mFetchCnt != 32'hFFFF_FFFF) mFetchCnt++;
      if (IF_flush) skidQ.delete();
      else if (wasHold) begin
         if (if_id_enable) void'(skidQ.pop_front());
      end else if (done && !mDead && !if_id_enable) skidQ.push_back('{word: imem_rdata, pc: mAddr});
      if (mux_sel_IF || (IF_flush && live)) nPc = pc_branch_value;
      else if (done && !mDead) nPc = mAddr + 32'd4;
      else nPc = mPc;
      if (mBusy && !done) begin
         if (IF_flush) mDead = 1;
      end else begin
         issue = pc_enable && !mux_sel_IF && (skidQ.size() == 0) &&
                 (wasIdle || (!IF_flush && ((done && !mDead) || wasHold)));
         mBusy = issue;
         mDead = 0;
         if (issue) mAddr = nPc;
      end
      mPc = nPc;
   endtask

   // Drive one cycle of inputs (redirect always accompanies flush) and step the model
   task automatic applyStimulus(input bit rst, input bit pe, input bit ie, input bit fl,
                                input logic [31:0] br, input bit rdy, input logic [31:0] rdata);
      reset           = rst;
      pc_enable       = pe;
      if_id_enable    = ie;
      IF_flush        = fl;
      mux_sel_IF      = fl;
      pc_branch_value = br;
      imem_ready      = rdy;
      imem_rdata      = rdata;
      stepModel();
   endtask

   typedef struct packed {
      bit          rst, pe, ie, fl, rdy;
      logic [31:0] br;
      bit          expReq;
      logic [31:0] expAddr;
   } dirRow_t;

   dirRow_t rows[18] = '{
      '{1,1,1,0,1, 32'h00, 0, 32'h00},
      '{1,1,1,0,1, 32'h00, 1, 32'h00},
      '{1,1,1,0,1, 32'h00, 1, 32'h04},
      '{1,1,1,0,0, 32'h00, 1, 32'h08},
      '{1,1,1,0,0, 32'h00, 1, 32'h08},
      '{1,1,1,0,1, 32'h00, 1, 32'h08},
      '{1,1,0,0,1, 32'h00, 1, 32'h0C},
      '{1,1,0,0,1, 32'h00, 0, 32'h0C},
      '{1,1,1,0,0, 32'h00, 0, 32'h0C},
      '{1,1,1,1,0, 32'h40, 1, 32'h10},
      '{1,1,1,0,1, 32'h00, 1, 32'h10},
      '{1,1,1,0,1, 32'h00, 0, 32'h10},
      '{1,1,1,0,1, 32'h00, 1, 32'h40},
      '{1,1,1,1,1, 32'h80, 1, 32'h44},
      '{1,1,1,0,0, 32'h00, 0, 32'h44},
      '{0,1,1,0,0, 32'h00, 1, 32'h80},
      '{1,0,1,0,1, 32'h00, 0, 32'h00},
      '{1,0,1,0,1, 32'h00, 0, 32'h00}
   };

   // Reset, directed scenarios, then randomized traffic
   initial begin
      logic [31:0] br;
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      repeat (2) begin
         @(negedge clock);
         applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      end
      for (int k = 0; k < 18; k++) begin
         @(negedge clock);
         compareModel();
         checkOutput($sformatf("dir%0d_req", k), 32'(imem_req), 32'(rows[k].expReq));
         checkOutput($sformatf("dir%0d_addr", k), imem_addr, rows[k].expAddr);
         applyStimulus(rows[k].rst, rows[k].pe, rows[k].ie, rows[k].fl, rows[k].br,
                       rows[k].rdy, $urandom);
      end
      for (int n = 0; n < 1500; n++) begin
         @(negedge clock);
         compareModel();
         br = {$urandom_range(3) == 0 ? 30'h3FFF_FFFE : 30'($urandom), 2'b00};
         applyStimulus($urandom_range(39) != 0, $urandom_range(9) < 8, $urandom_range(3) != 0,
                       $urandom_range(9) == 0, br, $urandom_range(9) < 6, $urandom);
      end
      @(negedge clock);
      compareModel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
